// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's single-word access channel to the data
// memory arbiter.
//   req, we, addr, wdata : request and payload, driven by the requester
//   gnt                  : combinational grant for the issue cycle
//   rvalid, rdata        : registered read response back to the requester
// Modports: master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
  parameter int WORD     = 16,
  parameter int ADDRESSL = 10
);
  logic                req;
  logic                we;
  logic [ADDRESSL-1:0] addr;
  logic [WORD-1:0]     wdata;
  logic                gnt;
  logic                rvalid;
  logic [WORD-1:0]     rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous-read data memory between
// requester A (CPU load/store) and requester B (debug/DMA loader). At most one
// single-word access is issued per cycle; read data returns two cycles after
// issue, only to the requester that issued the read.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   a, b                : requester channels (dmem_arbiter_if.slave)
//   mem_address         : memory address (0 when idle)
//   mem_writeData       : memory write data (0 when idle)
//   mem_memWrite/Read   : memory write / read enables
//   mem_readData        : memory read data, valid one cycle after memRead
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking; without
// it A has fixed priority over B.
module dmem_arbiter #(
  parameter int WORD     = 16,
  parameter int ADDRESSL = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_arbiter_if.slave       a,
  dmem_arbiter_if.slave       b,
  output logic [ADDRESSL-1:0] mem_address,
  output logic [WORD-1:0]     mem_writeData,
  output logic                mem_memWrite,
  output logic                mem_memRead,
  input  logic [WORD-1:0]     mem_readData
);

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

  logic            gnt_a, gnt_b;
  logic            s1_v, s2_v;
  owner_t          s1_own, s2_own;
  logic [WORD-1:0] rdata_a, rdata_b;

`ifdef DMEM_ARB_RR_EN
  owner_t rr_last;

  // Tie goes to whichever requester was not granted last.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      if (a.req && b.req) begin
        if (rr_last == OWN_B) gnt_a = 1'b1;
        else                  gnt_b = 1'b1;
      end else begin
        gnt_a = a.req;
        gnt_b = b.req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rr_last <= OWN_B;
    else if (gnt_a) rr_last <= OWN_A;
    else if (gnt_b) rr_last <= OWN_B;
  end
`else
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      gnt_a = a.req;
      gnt_b = b.req && !a.req;
    end
  end
`endif

  // Memory port is steered directly from the winner's payload.
  always_comb begin
    mem_address   = '0;
    mem_writeData = '0;
    mem_memWrite  = 1'b0;
    mem_memRead   = 1'b0;
    if (gnt_a) begin
      mem_address   = a.addr;
      mem_writeData = a.wdata;
      mem_memWrite  = a.we;
      mem_memRead   = !a.we;
    end else if (gnt_b) begin
      mem_address   = b.addr;
      mem_writeData = b.wdata;
      mem_memWrite  = b.we;
      mem_memRead   = !b.we;
    end
  end

  // Tag pipeline: stage 1 tracks the read the memory is currently serving,
  // stage 2 marks the cycle its data is presented to the owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_own  <= OWN_A;
      s2_v    <= 1'b0;
      s2_own  <= OWN_A;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      s1_v   <= mem_memRead;
      s1_own <= gnt_b ? OWN_B : OWN_A;
      s2_v   <= s1_v;
      s2_own <= s1_own;
      if (s1_v) begin
        if (s1_own == OWN_B) rdata_b <= mem_readData;
        else                 rdata_a <= mem_readData;
      end
    end
  end

  assign a.gnt    = gnt_a;
  assign b.gnt    = gnt_b;
  assign a.rvalid = s2_v && (s2_own == OWN_A);
  assign b.rvalid = s2_v && (s2_own == OWN_B);
  assign a.rdata  = rdata_a;
  assign b.rdata  = rdata_b;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by randomized traffic on both
// requesters, checked against a transaction-level model (shadow memory plus a
// queue of due read responses).
module tb_dmem_arbiter;
  localparam int WORD     = 16;
  localparam int ADDRESSL = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.WORD(WORD), .ADDRESSL(ADDRESSL)) a_if ();
  dmem_arbiter_if #(.WORD(WORD), .ADDRESSL(ADDRESSL)) b_if ();

  logic [ADDRESSL-1:0] mem_address;
  logic [WORD-1:0]     mem_writeData;
  logic                mem_memWrite;
  logic                mem_memRead;
  logic [WORD-1:0]     mem_readData;

  dmem_arbiter #(.WORD(WORD), .ADDRESSL(ADDRESSL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a             (a_if),
    .b             (b_if),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_memWrite  (mem_memWrite),
    .mem_memRead   (mem_memRead),
    .mem_readData  (mem_readData)
  );

  function automatic logic [WORD-1:0] init_word(input logic [ADDRESSL-1:0] ad);
    logic [WORD-1:0] x;
    x = WORD'(ad);
    return (x * 16'd257) ^ 16'hA5C3;
  endfunction

  // Synchronous-read single-port memory device.
  logic [WORD-1:0] dev_mem [int];
  always @(posedge clk) begin
    if (mem_memRead)
      mem_readData <= dev_mem.exists(int'(mem_address)) ? dev_mem[int'(mem_address)]
                                                        : init_word(mem_address);
    if (mem_memWrite)
      dev_mem[int'(mem_address)] = mem_writeData;
  end

  // Reference model state.
  typedef struct {
    int              due;
    bit              own;
    logic [WORD-1:0] data;
  } resp_t;

  logic [WORD-1:0] ref_mem [int];
  resp_t           resp_q [$];
  logic [WORD-1:0] exp_rd_a, exp_rd_b;
  bit              m_last;
  bit              eg_a, eg_b;
  logic            seen_ga;
  int              total = 0;
  int              bad = 0;
  int              cyc = 0;

  function automatic logic [WORD-1:0] ref_read(input logic [ADDRESSL-1:0] ad);
    return ref_mem.exists(int'(ad)) ? ref_mem[int'(ad)] : init_word(ad);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    bit    erv_a, erv_b;
    resp_t e;
    erv_a = 1'b0;
    erv_b = 1'b0;
    if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
      e = resp_q.pop_front();
      if (e.own) begin erv_b = 1'b1; exp_rd_b = e.data; end
      else       begin erv_a = 1'b1; exp_rd_a = e.data; end
    end
    check("a_rvalid", 32'(a_if.rvalid), 32'(erv_a));
    check("b_rvalid", 32'(b_if.rvalid), 32'(erv_b));
    check("a_rdata", 32'(a_if.rdata), 32'(exp_rd_a));
    check("b_rdata", 32'(b_if.rdata), 32'(exp_rd_b));
  endtask

  // Enter with inputs stable just after a rising edge; returns 1 time unit
  // after the next rising edge.
  task automatic step();
    logic                ew;
    logic [ADDRESSL-1:0] ea;
    logic [WORD-1:0]     ewd;
    #3;
    eg_a = 1'b0;
    eg_b = 1'b0;
    if (rst_n) begin
      if (a_if.req && b_if.req) begin
`ifdef DMEM_ARB_RR_EN
        if (m_last) eg_a = 1'b1;
        else        eg_b = 1'b1;
`else
        eg_a = 1'b1;
`endif
      end else begin
        eg_a = a_if.req;
        eg_b = b_if.req;
      end
    end
    ew  = eg_a ? a_if.we    : eg_b ? b_if.we    : 1'b0;
    ea  = eg_a ? a_if.addr  : eg_b ? b_if.addr  : '0;
    ewd = eg_a ? a_if.wdata : eg_b ? b_if.wdata : '0;
    seen_ga = a_if.gnt;
    check("a_gnt", 32'(a_if.gnt), 32'(eg_a));
    check("b_gnt", 32'(b_if.gnt), 32'(eg_b));
    check("mem_memWrite", 32'(mem_memWrite), 32'((eg_a || eg_b) && ew));
    check("mem_memRead", 32'(mem_memRead), 32'((eg_a || eg_b) && !ew));
    check("mem_address", 32'(mem_address), 32'(ea));
    check("mem_writeData", 32'(mem_writeData), 32'(ewd));
    @(posedge clk);
    if (rst_n && (eg_a || eg_b)) begin
      if (ew) ref_mem[int'(ea)] = ewd;
      else    resp_q.push_back('{due: cyc + 2, own: eg_b, data: ref_read(ea)});
      m_last = eg_b;
    end
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    resp_q.delete();
    exp_rd_a = '0;
    exp_rd_b = '0;
    m_last   = 1'b1;
    #1;
    check_outputs();
  endtask

  task automatic drive_a(input logic r, input logic w, input logic [ADDRESSL-1:0] ad,
                         input logic [WORD-1:0] d);
    a_if.req = r; a_if.we = w; a_if.addr = ad; a_if.wdata = d;
  endtask

  task automatic drive_b(input logic r, input logic w, input logic [ADDRESSL-1:0] ad,
                         input logic [WORD-1:0] d);
    b_if.req = r; b_if.we = w; b_if.addr = ad; b_if.wdata = d;
  endtask

  initial begin
    logic [3:0] pat;
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0);
    exp_rd_a = '0;
    exp_rd_b = '0;
    m_last   = 1'b1;

    // Reset state, with a pending request that must not be granted.
    #1;
    check_outputs();
    drive_a(1'b1, 1'b0, 10'd3, '0);
    step();
    step();
    drive_a(1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;

    // Contention straight out of reset.
    drive_a(1'b1, 1'b0, 10'd20, '0);
    drive_b(1'b1, 1'b0, 10'd21, '0);
    pat = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      pat[k] = seen_ga;
    end
`ifdef DMEM_ARB_RR_EN
    check("contention_pattern", 32'(pat), 32'(4'b0101));
`else
    check("contention_pattern", 32'(pat), 32'(4'b1111));
`endif
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0);
    step();
    step();

    // Single read of a preloaded word.
    drive_a(1'b1, 1'b1, 10'd5, 16'h1234);
    step();
    drive_a(1'b1, 1'b0, 10'd5, '0);
    step();
    drive_a(1'b0, 1'b0, '0, '0);
    step();
    check("single_read_rvalid", 32'(a_if.rvalid), 32'd1);
    check("single_read_rdata", 32'(a_if.rdata), 32'h1234);
    check("single_read_b_rvalid", 32'(b_if.rvalid), 32'd0);

    // Write then read the same address in the following cycle.
    drive_a(1'b1, 1'b1, 10'd9, 16'hBEEF);
    step();
    drive_a(1'b1, 1'b0, 10'd9, '0);
    step();
    drive_a(1'b0, 1'b0, '0, '0);
    step();
    check("raw_rdata", 32'(a_if.rdata), 32'hBEEF);

    // Interleaved reads from A then B.
    drive_a(1'b1, 1'b1, 10'd1, 16'h0011);
    step();
    drive_a(1'b1, 1'b1, 10'd2, 16'h0022);
    step();
    drive_a(1'b1, 1'b0, 10'd1, '0);
    step();
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b1, 1'b0, 10'd2, '0);
    step();
    check("interleave_a_rdata", 32'(a_if.rdata), 32'h0011);
    check("interleave_a_rvalid", 32'(a_if.rvalid), 32'd1);
    drive_b(1'b0, 1'b0, '0, '0);
    step();
    check("interleave_b_rdata", 32'(b_if.rdata), 32'h0022);
    check("interleave_b_rvalid", 32'(b_if.rvalid), 32'd1);
    check("interleave_a_hold", 32'(a_if.rdata), 32'h0011);

    // Reset while a read is in flight.
    drive_a(1'b1, 1'b0, 10'd5, '0);
    step();
    drive_a(1'b0, 1'b0, '0, '0);
    assert_reset();
    step();
    step();
    check("rst_flight_rvalid", 32'({a_if.rvalid, b_if.rvalid}), 32'd0);
    check("rst_flight_rdata", 32'({a_if.rdata, b_if.rdata}), 32'd0);
    rst_n = 1'b1;
    step();
    step();

    // Idle.
    for (int k = 0; k < 3; k++) step();

    // Randomized traffic; a request is held until the model grants it.
    for (int n = 0; n < 3000; n++) begin
      if (!a_if.req || eg_a)
        drive_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                10'($urandom_range(0, 15)), 16'($urandom));
      if (!b_if.req || eg_b)
        drive_b(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                10'($urandom_range(0, 15)), 16'($urandom));
      if ($urandom_range(0, 499) == 0) begin
        assert_reset();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
